// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver.
//   Two-flop synchronisers on ps2_clk/ps2_dat, a run-length filter on the
//   clock line, and an FSM that deserialises 11-bit frames (start, 8 data
//   LSB-first, odd parity, stop). Each good byte is presented as a one-cycle
//   strobe; bad frames (parity, stop, inter-edge timeout) give keyb_error.
// Ports:
//   wb_clk     system clock, all logic on its rising edge
//   sys_init   synchronous active-high reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_dat    raw PS/2 data (asynchronous)
//   keyb_data  last good byte, held until the next good frame
//   keyb_valid one-cycle strobe: keyb_data is new
//   keyb_error one-cycle strobe: frame dropped
//   busy       FSM is outside IDLE
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic       wb_clk,
  input  logic       sys_init,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] keyb_data,
  output logic       keyb_valid,
  output logic       keyb_error,
  output logic       busy
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      FLT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0]   TMO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_f_q, clk_f_d, clk_f_prev_q;
  logic [7:0]    flt_cnt_q, flt_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;

  logic clk_s, dat_s, fall, tmo_hit;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  // One-cycle strobe on the filtered clock's falling edge; dat_s is
  // sampled in this same cycle.
  assign fall    = clk_f_prev_q & ~clk_f_q;
  assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_MAX);

  // Clock filter: clk_f only follows clk_s after FILTER_LEN consecutive
  // differing samples; any agreeing sample restarts the count.
  always_comb begin
    flt_cnt_d = '0;
    clk_f_d   = clk_f_q;
    if (clk_s != clk_f_q) begin
      if (flt_cnt_q == FLT_LAST) clk_f_d = clk_s;
      else                       flt_cnt_d = flt_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    if (state_q == IDLE || fall || tmo_hit) tmo_d = '0;
    else if (tmo_q != TMO_MAX)              tmo_d = tmo_q + TW'(1);
    else                                    tmo_d = tmo_q;

    // Timeout takes priority over a coincident fall.
    if (tmo_hit) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      error_d   = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          // A high sample here is just line noise / idle, not an error.
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          if (dat_s && (^{shift_q, par_q})) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk) begin
    if (sys_init) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
      flt_cnt_q    <= '0;
      tmo_q        <= '0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      dat_sync_q   <= {dat_sync_q[0], ps2_dat};
      clk_f_q      <= clk_f_d;
      clk_f_prev_q <= clk_f_q;
      flt_cnt_q    <= flt_cnt_d;
      tmo_q        <= tmo_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      error_q      <= error_d;
    end
  end

  assign keyb_data  = data_q;
  assign keyb_valid = valid_q;
  assign keyb_error = error_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx. PS/2 timing is scaled down: one bit period is
// 2*HALF wb_clk cycles and the timeout is shortened to keep runs short.
module tb_ps2_rx;
  localparam int F    = 8;
  localparam int T    = 400;
  localparam int HALF = 50;

  logic       wb_clk = 1'b0;
  logic       sys_init = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] keyb_data;
  logic       keyb_valid, keyb_error, busy;

  ps2_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .wb_clk(wb_clk), .sys_init(sys_init), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .keyb_data(keyb_data), .keyb_valid(keyb_valid), .keyb_error(keyb_error),
    .busy(busy)
  );

  always #5 wb_clk = ~wb_clk;

  int checks = 0, failures = 0;
  int cyc_cnt = 0, last_fall = 0;
  int nval = 0, nerr = 0, nboth = 0;
  logic [7:0] vq[$];

  always @(posedge wb_clk) cyc_cnt++;

  always @(negedge wb_clk) begin
    if (keyb_valid) begin nval++; vq.push_back(keyb_data); end
    if (keyb_error) nerr++;
    if (keyb_valid && keyb_error) nboth++;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge wb_clk);
  endtask

  // Data set while the clock is high, then a low half-period.
  // Optional low glitch of glen cycles in the middle of the high phase.
  task automatic send_bit(bit b, bit glitch, int glen);
    ps2_dat = b;
    if (glitch) begin
      cyc(20); ps2_clk = 1'b0; cyc(glen); ps2_clk = 1'b1; cyc(HALF - 20 - glen);
    end else cyc(HALF);
    ps2_clk = 1'b0; last_fall = cyc_cnt;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] d, bit pflip, bit stopv,
                            logic [10:0] gmask, int glen, bit cbusy);
    logic [10:0] fr;
    fr = {stopv, (~^d) ^ pflip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      send_bit(fr[i], gmask[i], glen);
      if (cbusy) chk($sformatf("busy_bit%0d", i), {31'b0, busy}, (i < 10) ? 1 : 0);
    end
    ps2_dat = 1'b1;
    cyc(2 * HALF);
  endtask

  initial begin
    int v0, e0, dly;
    logic [7:0] b;
    cyc(5);
    sys_init = 1'b0;
    cyc(2);
    chk("rst_data", {24'b0, keyb_data}, 32'h00);
    chk("rst_valid", {31'b0, keyb_valid}, 0);
    chk("rst_error", {31'b0, keyb_error}, 0);
    chk("rst_busy", {31'b0, busy}, 0);

    // Single good frame 1C with busy tracked per bit
    send_frame(8'h1C, 0, 1, '0, 0, 1);
    chk("1c_nval", nval, 1);
    chk("1c_data", {24'b0, keyb_data}, 32'h1C);
    chk("1c_nerr", nerr, 0);

    // Back-to-back E0 F0 75
    v0 = nval;
    send_frame(8'hE0, 0, 1, '0, 0, 0);
    send_frame(8'hF0, 0, 1, '0, 0, 0);
    send_frame(8'h75, 0, 1, '0, 0, 0);
    chk("b2b_nval", nval - v0, 3);
    chk("b2b_q0", {24'b0, vq[1]}, 32'hE0);
    chk("b2b_q1", {24'b0, vq[2]}, 32'hF0);
    chk("b2b_q2", {24'b0, vq[3]}, 32'h75);
    chk("b2b_hold", {24'b0, keyb_data}, 32'h75);

    // Parity error, then stop error
    v0 = nval; e0 = nerr;
    send_frame(8'h1C, 1, 1, '0, 0, 0);
    chk("par_nerr", nerr - e0, 1);
    chk("par_nval", nval - v0, 0);
    chk("par_hold", {24'b0, keyb_data}, 32'h75);
    v0 = nval; e0 = nerr;
    send_frame(8'h1C, 0, 0, '0, 0, 0);
    chk("stop_nerr", nerr - e0, 1);
    chk("stop_nval", nval - v0, 0);
    chk("stop_hold", {24'b0, keyb_data}, 32'h75);

    // Timeout: start + 4 data bits of 0x0F, then clock idles high.
    // Expected error lag from the last pin fall: 2 sync + F filter + 1 fall
    // cycle + T count + 1 strobe register = T+F+4.
    v0 = nval; e0 = nerr;
    b = 8'h0F;
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) send_bit(b[i], 0, 0);
    ps2_dat = 1'b1;
    while (!keyb_error && (cyc_cnt - last_fall) < T + F + 60) @(negedge wb_clk);
    dly = cyc_cnt - last_fall;
    chk("tmo_seen", {31'b0, keyb_error}, 1);
    chk("tmo_early", {31'b0, dly < T + F + 3}, 0);
    chk("tmo_late", {31'b0, dly > T + F + 5}, 0);
    cyc(1);
    chk("tmo_busy", {31'b0, busy}, 0);
    cyc(2 * HALF);
    chk("tmo_nerr", nerr - e0, 1);
    chk("tmo_nval", nval - v0, 0);
    send_frame(8'h29, 0, 1, '0, 0, 0);
    chk("tmo_rec", {24'b0, keyb_data}, 32'h29);
    chk("tmo_rec_nval", nval - v0, 1);

    // Short glitches (F-1 cycles) on several bits are filtered out
    v0 = nval; e0 = nerr;
    send_frame(8'h5A, 0, 1, 11'b001_0100_1010, F - 1, 0);
    chk("gs_nval", nval - v0, 1);
    chk("gs_nerr", nerr - e0, 0);
    chk("gs_data", {24'b0, keyb_data}, 32'h5A);

    // Long glitch (F+2) adds a bit: error or wrong byte, then idle again
    v0 = nval; e0 = nerr;
    send_frame(8'h5A, 0, 1, 11'b000_0000_1000, F + 2, 0);
    cyc(T + F + 20);
    chk("gl_bad", {31'b0, (nerr > e0) || (nval > v0 && keyb_data != 8'h5A)}, 1);
    chk("gl_busy", {31'b0, busy}, 0);

    // Reset after the 5th data bit aborts the frame silently
    v0 = nval; e0 = nerr;
    b = 8'hAA;
    send_bit(1'b0, 0, 0);
    for (int i = 0; i < 5; i++) send_bit(b[i], 0, 0);
    chk("rmf_busy_pre", {31'b0, busy}, 1);
    sys_init = 1'b1;
    cyc(1);
    sys_init = 1'b0;
    chk("rmf_busy", {31'b0, busy}, 0);
    ps2_dat = 1'b1;
    cyc(T + 50);
    chk("rmf_nval", nval - v0, 0);
    chk("rmf_nerr", nerr - e0, 0);
    chk("rmf_data", {24'b0, keyb_data}, 32'h00);
    send_frame(8'h16, 0, 1, '0, 0, 0);
    chk("rmf_rec_nval", nval - v0, 1);
    chk("rmf_rec_data", {24'b0, keyb_data}, 32'h16);

    chk("excl", nboth, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
